seg7_bus_decoder: RTL
=====================

// Module: seg7_bus_decoder
// PURPOSE
// - Receive end of the multiplexed 7-seg display bus: samples active-low segment + anode lines, recovers 4-bit digit code per position.
// - Sits beside display driver (or on pins) as scoreboard capture/self-check; feeds valid/ready stream + flat digit snapshot.
// PARAMETERS
// - NUM_DIGITS     4   number of anode positions (>=2)
// - STABLE_CYCLES  8   consecutive identical samples required before capture (>=2)
// PORTS
// - clk          in   1              system clock, single domain
// - reset        in   1              synchronous, active-high
// - segs_in      in   7              segment lines {g,f,e,d,c,b,a}, active-low, asynchronous
// - an_in        in   NUM_DIGITS     anode lines, active-low, asynchronous
// - digit_out    out  4              decoded code of captured position
// - digit_idx    out  clog2(NUM_DIGITS)  position index (bit i of an_in low -> i)
// - digit_err    out  1              pattern not in decode table; digit_out=0
// - digit_valid  out  1              stream valid
// - digit_ready  in   1              stream ready
// - frame_done   out  1              1-cycle pulse when idx NUM_DIGITS-1 is captured
// - overrun      out  1              sticky: capture dropped while valid&&!ready
// - digits_flat  out  4*NUM_DIGITS   last code per position, slot i = [4i+3:4i]
// BEHAVIOUR
// - Reset: all outputs 0; sync regs and prev sample = all-ones (bus idle); cnt=0; state SETTLE.
// - Sync: 2-flop synchroniser on {segs_in,an_in}; s = stage-2 value.
// - Stability: each edge, s==prev ? cnt<=sat(cnt+1) : cnt<=0, state<=SETTLE; prev<=s.
// - FSM SETTLE: cnt==STABLE_CYCLES-1 -> capture attempt, go CAPTURED. CAPTURED: hold until s changes -> SETTLE.
//   One capture attempt per stable window, never repeated for a held value.
// - Capture attempt valid only if exactly one anode low; zero or >=2 low (ghosting) -> no capture, no flags, still -> CAPTURED.
// - Decode table (segs, active-low) -> code:
//   0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000,
//   8:0000000, 9:0010000, A:0001000, B:0000011, C:1011111, D:1001111, E:1111101, F:0000111.
//   Any other pattern -> digit_err=1, code 0.
// - Latency: inputs changed and held from sampling edge N -> digit_valid high after edge N+STABLE_CYCLES+2.
// - On accepted capture, same edge: digit_out/idx/err loaded, digit_valid<=1, digits_flat slot written (err -> slot 0).
// - frame_done pulses on that edge if idx==NUM_DIGITS-1.
// - Handshake: digit_valid&&digit_ready -> valid<=0. Outputs stable while valid&&!ready.
// - Capture with valid&&!ready: stream outputs untouched, overrun<=1, digits_flat still updated.
// - Same-edge ready+new capture: new word loaded, valid stays 1, no overrun.
// - overrun cleared only by reset.
// - Reset mid-window: cnt, state, pending word discarded; next capture needs full fresh window.
// - cnt saturates at STABLE_CYCLES-1; no wrap.
// CONFIGURATION
// - SEG7_BLANK_DETECT_EN defined: segs==1111111 (all off) with one anode low is a blank.
//   Blank: no capture, no digit_err, digits_flat unchanged.
// - Not defined: blank is an ordinary unknown pattern: captured with digit_err=1, code 0, slot written 0.
// TESTING
// - STABLE_CYCLES=8, hold an=1110 segs=0100100, ready=1 -> one valid beat after 10 edges: code 2, idx 0, err 0; no repeat while held.
// - Scan an 1110/1101/1011/0111 with 3,1,A,F, each held 20 cycles -> 4 beats; frame_done on idx 3; digits_flat=16'hFA13.
// - Hold each value 5 cycles (<STABLE_CYCLES) -> no digit_valid, digits_flat unchanged.
// - ready=0, two positions captured -> first word held; overrun=1; digits_flat has both; after ready=1, one beat of first word only.
// - an=1100 segs=0000000 -> no capture.
//   segs=1111111 an=1110: with SEG7_BLANK_DETECT_EN no beat; without, beat err=1 code 0.
// - Assert reset at cycle 5 of a settle window -> all outputs 0; capture only 10 edges after reset release with input held.

Source files
------------

// File: rtl/seg7_bus_decoder.sv
// Receive-side decoder for a multiplexed active-low 7-segment bus: recovers per-position digit codes.
// Optional build macro SEG7_BLANK_DETECT_EN treats an all-off segment pattern on one anode as a blank.
module seg7_bus_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [6:0]                    segs_in,
  input  logic [NUM_DIGITS-1:0]         an_in,
  output logic [3:0]                    digit_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          digit_err,
  output logic                          digit_valid,
  input  logic                          digit_ready,
  output logic                          frame_done,
  output logic                          overrun,
  output logic [4*NUM_DIGITS-1:0]       digits_flat,
  output logic                          state_dbg
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int SW = 7 + NUM_DIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic {SETTLE = 1'b0, CAPTURED = 1'b1} state_t;

  // Stream handshake: a word transfers on any edge where digit_valid && digit_ready;
  // while digit_valid && !digit_ready the word outputs hold steady.

  logic [SW-1:0]         sync1, sync2, prev;
  logic [CW-1:0]         cnt;
  state_t                state, state_nx;
  logic [6:0]            s_segs;
  logic [NUM_DIGITS-1:0] an_low;
  logic                  stable, attempt, onehot, is_blank, capture;
  logic [IW-1:0]         cap_idx;
  logic [3:0]            dec_code;
  logic                  dec_err;

  assign s_segs    = sync2[SW-1 -: 7];
  assign an_low    = ~sync2[NUM_DIGITS-1:0];
  assign stable    = (sync2 == prev);
  assign attempt   = (state == SETTLE) && stable && (cnt == CNT_MAX);
  assign onehot    = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
  assign state_dbg = (state == CAPTURED);

`ifdef SEG7_BLANK_DETECT_EN
  assign is_blank = (s_segs == 7'h7F);
`else
  assign is_blank = 1'b0;
`endif

  assign capture = attempt && onehot && !is_blank;

  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) cap_idx = IW'(i);
    end
  end

  always_comb begin
    dec_err  = 1'b0;
    dec_code = 4'h0;
    case (s_segs)
      7'b1000000: dec_code = 4'h0;
      7'b1111001: dec_code = 4'h1;
      7'b0100100: dec_code = 4'h2;
      7'b0110000: dec_code = 4'h3;
      7'b0011001: dec_code = 4'h4;
      7'b0010010: dec_code = 4'h5;
      7'b0000010: dec_code = 4'h6;
      7'b1111000: dec_code = 4'h7;
      7'b0000000: dec_code = 4'h8;
      7'b0010000: dec_code = 4'h9;
      7'b0001000: dec_code = 4'hA;
      7'b0000011: dec_code = 4'hB;
      7'b1011111: dec_code = 4'hC;
      7'b1001111: dec_code = 4'hD;
      7'b1111101: dec_code = 4'hE;
      7'b0000111: dec_code = 4'hF;
      default:    dec_err  = 1'b1;
    endcase
  end

  // A held value gets exactly one capture attempt; any change re-arms the window.
  always_comb begin
    state_nx = state;
    if (!stable)      state_nx = SETTLE;
    else if (attempt) state_nx = CAPTURED;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
      cnt   <= '0;
      state <= SETTLE;
    end else begin
      sync1 <= {segs_in, an_in};
      sync2 <= sync1;
      prev  <= sync2;
      state <= state_nx;
      if (!stable)             cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_out   <= '0;
      digit_idx   <= '0;
      digit_err   <= 1'b0;
      digit_valid <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      digits_flat <= '0;
    end else begin
      frame_done <= 1'b0;
      if (digit_valid && digit_ready) digit_valid <= 1'b0;
      if (capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (IW'(i) == cap_idx) digits_flat[4*i +: 4] <= dec_err ? 4'h0 : dec_code;
        end
        frame_done <= (cap_idx == IW'(NUM_DIGITS - 1));
        if (!digit_valid || digit_ready) begin
          digit_out   <= dec_err ? 4'h0 : dec_code;
          digit_idx   <= cap_idx;
          digit_err   <= dec_err;
          digit_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
